imem_responder: RTL and testbench

//  Instruction-memory responder for mcu0: the memory end of the PC fetch interface.

---
 rtl/imem_responder_if.sv | 22 ++
 rtl/imem_responder.sv | 91 +++++++++
 tb/tb_imem_responder.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/imem_responder_if.sv
// rtl/imem_responder_if.sv - fetch request/response bus between the fetch stage and instruction memory
interface imem_responder_if #(
    parameter int W = 16
);
    logic         req_valid;
    logic         req_ready;
    logic [W-1:0] req_addr;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [W-1:0] rsp_data;
    logic         rsp_err;

    modport master (
        output req_valid, req_addr, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_err
    );

    modport slave (
        input  req_valid, req_addr, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_err
    );
endinterface

// File: rtl/imem_responder.sv
// rtl/imem_responder.sv - instruction memory responder with programmable wait cycles and a side load port
module imem_responder #(
    parameter int W     = 16,
    parameter int DEPTH = 256,
    parameter int WAIT  = 1
) (
    input  logic             clock,
    input  logic             reset_n,
    imem_responder_if.slave  bus,
    input  logic             ld_en,
    input  logic [W-1:0]     ld_addr,
    input  logic [W-1:0]     ld_data
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t       state, state_nx;
    logic [2:0]   cnt;
    logic [W-1:0] addr_q;
    logic [W-1:0] rsp_data_q;
    logic         rsp_err_q;

    logic [W-1:0] mem [DEPTH];

    logic [W-2:0] word_idx;
    logic         word_err;
    logic [W-1:0] word_rd;
    logic         accept;
    logic         enter_resp;

    assign accept     = (state == S_IDLE) && bus.req_valid;
    assign enter_resp = (state == S_WAIT) && (state_nx == S_RESP);

    assign word_idx = addr_q[W-1:1];
    assign word_err = addr_q[0] | (32'(word_idx) >= DEPTH);
    assign word_rd  = word_err ? '0 : mem[word_idx[AW-1:0]];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Every accept spends at least one edge in S_WAIT so the response lands WAIT+1 edges later.
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: if (accept) state_nx = S_WAIT;
            S_WAIT: if (cnt == 3'd0) state_nx = S_RESP;
            S_RESP: if (bus.rsp_ready) state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        bus.req_ready = (state == S_IDLE);
        bus.rsp_valid = (state == S_RESP);
        bus.rsp_data  = rsp_data_q;
        bus.rsp_err   = rsp_err_q;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt        <= 3'd0;
            addr_q     <= '0;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
        end else begin
            if (accept) begin
                addr_q <= bus.req_addr;
                cnt    <= 3'(WAIT);
            end else if (state == S_WAIT && cnt != 3'd0) begin
                cnt <= cnt - 3'd1;
            end
            // Array read sees the pre-edge contents, so a same-edge load returns the old word.
            if (enter_resp) begin
                rsp_data_q <= word_rd;
                rsp_err_q  <= word_err;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (ld_en && (32'(ld_addr) < DEPTH)) begin
            mem[ld_addr[AW-1:0]] <= ld_data;
        end
    end
endmodule

// File: tb/tb_imem_responder.sv
// tb/tb_imem_responder.sv - directed bench for imem_responder in WAIT=1, WAIT=0 and WAIT=7 builds
module tb_imem_responder;
    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        ld_en = 1'b0;
    logic [15:0] ld_addr = '0;
    logic [15:0] ld_data = '0;

    logic        rv [3];
    logic [15:0] ra [3];
    logic        rr [3];
    logic        rdy [3];
    logic        vo [3];
    logic [15:0] rd [3];
    logic        re [3];

    int total = 0;
    int bad   = 0;
    int lat_exp [3] = '{2, 1, 8};

    always #5 clock = ~clock;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int WT = (g == 0) ? 1 : (g == 1) ? 0 : 7;
        imem_responder_if #(.W(16)) bus ();
        assign bus.req_valid = rv[g];
        assign bus.req_addr  = ra[g];
        assign bus.rsp_ready = rr[g];
        assign rdy[g] = bus.req_ready;
        assign vo[g]  = bus.rsp_valid;
        assign rd[g]  = bus.rsp_data;
        assign re[g]  = bus.rsp_err;
        imem_responder #(.W(16), .DEPTH(256), .WAIT(WT)) u_dut (
            .clock   (clock),
            .reset_n (reset_n),
            .bus     (bus),
            .ld_en   (ld_en),
            .ld_addr (ld_addr),
            .ld_data (ld_data)
        );
    end

    typedef struct {
        logic [15:0] addr;
        logic [15:0] data;
        logic        err;
    } vec_t;

    vec_t tv [8];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic load(input logic [15:0] a, input logic [15:0] d);
        @(negedge clock);
        ld_en = 1'b1; ld_addr = a; ld_data = d;
        @(negedge clock);
        ld_en = 1'b0;
    endtask

    // Called at a negedge; returns at the negedge right after the accept edge.
    task automatic start_req(input int s, input logic [15:0] a);
        int n = 0;
        rv[s] = 1'b1; ra[s] = a;
        while (!rdy[s] && n < 50) begin
            @(negedge clock); n++;
        end
        if (!rdy[s]) chk("accept_timeout", 32'(rdy[s]), 32'd1);
        @(negedge clock);
        rv[s] = 1'b0;
    endtask

    task automatic wait_rsp(input int s, output int lat);
        lat = 0;
        while (!vo[s] && lat < 20) begin
            @(negedge clock); lat++;
        end
    endtask

    task automatic fetch(input int s, input logic [15:0] a, input logic [15:0] ed, input logic ee, input string nm);
        int lat;
        rr[s] = 1'b1;
        start_req(s, a);
        wait_rsp(s, lat);
        chk({nm, "_lat"}, 32'(lat), 32'(lat_exp[s]));
        chk({nm, "_data"}, 32'(rd[s]), 32'(ed));
        chk({nm, "_err"}, 32'(re[s]), 32'(ee));
        @(negedge clock);
        chk({nm, "_retire"}, 32'(vo[s]), 32'd0);
    endtask

    initial begin
        int lat;
        for (int i = 0; i < 3; i++) begin
            rv[i] = 1'b0; ra[i] = '0; rr[i] = 1'b1;
        end
        tv[0] = '{16'h0000, 16'h1111, 1'b0};
        tv[1] = '{16'h0002, 16'h2222, 1'b0};
        tv[2] = '{16'h0004, 16'h3333, 1'b0};
        tv[3] = '{16'h0006, 16'h4444, 1'b0};
        tv[4] = '{16'h0003, 16'h0000, 1'b1};
        tv[5] = '{16'h0200, 16'h0000, 1'b1};
        tv[6] = '{16'h01FE, 16'hA5A5, 1'b0};
        tv[7] = '{16'hFFFE, 16'h0000, 1'b1};

        repeat (2) @(negedge clock);
        for (int s = 0; s < 3; s++) begin
            chk("rst_req_ready", 32'(rdy[s]), 32'd1);
            chk("rst_rsp_valid", 32'(vo[s]), 32'd0);
            chk("rst_rsp_data", 32'(rd[s]), 32'd0);
            chk("rst_rsp_err", 32'(re[s]), 32'd0);
        end

        load(16'd0, 16'h1111);
        load(16'd1, 16'h2222);
        load(16'd2, 16'h3333);
        load(16'd3, 16'h4444);
        load(16'd255, 16'hA5A5);
        load(16'd256, 16'hDEAD);
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);

        for (int s = 0; s < 3; s++)
            for (int i = 0; i < 8; i++)
                fetch(s, tv[i].addr, tv[i].data, tv[i].err, $sformatf("vec%0d_%0d", s, i));

        rr[0] = 1'b0;
        start_req(0, 16'h0004);
        wait_rsp(0, lat);
        chk("bp_lat", 32'(lat), 32'd2);
        for (int k = 0; k < 5; k++) begin
            @(negedge clock);
            chk("bp_valid", 32'(vo[0]), 32'd1);
            chk("bp_data", 32'(rd[0]), 32'h3333);
            chk("bp_ready", 32'(rdy[0]), 32'd0);
        end
        rr[0] = 1'b1;
        @(negedge clock);
        chk("bp_release", 32'(vo[0]), 32'd0);
        @(negedge clock);
        chk("bp_single", 32'(vo[0]), 32'd0);
        chk("bp_idle_ready", 32'(rdy[0]), 32'd1);

        start_req(0, 16'h0004);
        @(negedge clock);
        ld_en = 1'b1; ld_addr = 16'd2; ld_data = 16'hBEEF;
        @(negedge clock);
        ld_en = 1'b0;
        chk("coll_valid", 32'(vo[0]), 32'd1);
        chk("coll_old", 32'(rd[0]), 32'h3333);
        @(negedge clock);
        fetch(0, 16'h0004, 16'hBEEF, 1'b0, "coll_refetch");

        start_req(0, 16'h0006);
        ld_en = 1'b1; ld_addr = 16'd3; ld_data = 16'hCAFE;
        @(negedge clock);
        ld_en = 1'b0;
        @(negedge clock);
        chk("waitwr_valid", 32'(vo[0]), 32'd1);
        chk("waitwr_new", 32'(rd[0]), 32'hCAFE);
        @(negedge clock);

        start_req(0, 16'h0002);
        reset_n = 1'b0;
        #1;
        chk("rstwait_valid", 32'(vo[0]), 32'd0);
        chk("rstwait_ready", 32'(rdy[0]), 32'd1);
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        chk("rstwait_stays_idle", 32'(vo[0]), 32'd0);
        fetch(0, 16'h0002, 16'h2222, 1'b0, "post_rst");

        rr[0] = 1'b0;
        start_req(0, 16'h0000);
        wait_rsp(0, lat);
        chk("rstresp_pre", 32'(rd[0]), 32'h1111);
        reset_n = 1'b0;
        #1;
        chk("rstresp_valid", 32'(vo[0]), 32'd0);
        chk("rstresp_data", 32'(rd[0]), 32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        rr[0] = 1'b1;
        @(negedge clock);
        fetch(2, 16'h0002, 16'h2222, 1'b0, "post_rst7");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
